// File: rtl/halut_pkg.sv
// halut_pkg: shared constants and types for the HALUT datapath.
//   M, DecoderUnits  - output row geometry (columns per row, columns per decoder group)
//   DecUnitsX        - number of parallel decoder-group lanes
//   ResultWidth      - width of one result word
//   coll_state_e     - read-side state of the result collector
//   Err*             - bit positions inside the collector's sticky error vector
package halut_pkg;

  localparam int unsigned M            = 8;
  localparam int unsigned DecoderUnits = 4;
  localparam int unsigned DecUnitsX    = M / DecoderUnits;
  localparam int unsigned ResultWidth  = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } coll_state_e;

  localparam int unsigned ErrOverflow  = 0;
  localparam int unsigned ErrDuplicate = 1;
  localparam int unsigned ErrRange     = 2;
  localparam int unsigned ErrWidth     = 3;

endpackage

// File: rtl/halut_row_bank.sv
// halut_row_bank: one row buffer of the result collector.
// Holds M result words plus a per-column fill bitmap.
//   clk_i, rst_ni  - clock, asynchronous active-low reset (bitmap only)
//   clear_i        - synchronous bitmap clear (has priority over writes)
//   wr_en_i        - per-lane write enable, already qualified by the caller
//   wr_addr_i      - per-lane column index
//   wr_data_i      - per-lane result word
//   rd_idx_i       - read column index
//   rd_data_o      - word stored at rd_idx_i (combinational read)
//   full_o         - pulse: this cycle's writes make the bitmap all-ones
//   dup_o          - pulse: a write hit a column that was already filled
module halut_row_bank #(
  parameter int unsigned M           = 8,
  parameter int unsigned Lanes       = 2,
  parameter int unsigned ResultWidth = 32,
  parameter int unsigned AddrWidth   = $clog2(M)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic [Lanes-1:0]                    wr_en_i,
  input  logic [Lanes-1:0][AddrWidth-1:0]     wr_addr_i,
  input  logic [Lanes-1:0][ResultWidth-1:0]   wr_data_i,
  input  logic [AddrWidth-1:0]                rd_idx_i,
  output logic [ResultWidth-1:0]              rd_data_o,
  output logic                                full_o,
  output logic                                dup_o
);

  logic [ResultWidth-1:0] mem_q [M];
  logic [M-1:0]           bitmap_q, bitmap_d;
  logic [M-1:0]           set_bits;
  logic [Lanes-1:0]       dup_lane;

  always_comb begin
    set_bits = '0;
    for (int x = 0; x < Lanes; x++) begin
      if (wr_en_i[x]) set_bits[wr_addr_i[x]] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < Lanes; gi++) begin : g_dup
      assign dup_lane[gi] = wr_en_i[gi] & bitmap_q[wr_addr_i[gi]];
    end
  endgenerate

  assign dup_o = |dup_lane;
  // Gated by a write so an already-complete bank does not keep re-signalling.
  assign full_o = (|wr_en_i) & (&(bitmap_q | set_bits));

  assign bitmap_d = clear_i ? '0 : (bitmap_q | set_bits);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bitmap_q <= '0;
    else         bitmap_q <= bitmap_d;
  end

  // Storage has no reset; lanes own disjoint columns so ports never collide.
  always_ff @(posedge clk_i) begin
    for (int x = 0; x < Lanes; x++) begin
      if (wr_en_i[x]) mem_q[wr_addr_i[x]] <= wr_data_i[x];
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/halut_result_collector.sv
// halut_result_collector: assembles per-decoder-group result streams into
// complete rows of M words using two row banks (one fills, one drains) and
// streams each finished row in column order.
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   clear_i           - synchronous clear, same effect as reset
//   result_i/valid_i/m_addr_i - per-lane result word, valid and column index
//   out_data_o/out_m_addr_o/out_last_o/out_valid_o, out_ready_i - row stream
//   row_idx_o         - index of the row currently being drained
//   err_o             - sticky errors: overflow, duplicate, lane address range
module halut_result_collector #(
  parameter int unsigned M            = halut_pkg::M,
  parameter int unsigned DecoderUnits = halut_pkg::DecoderUnits,
  parameter int unsigned DecUnitsX    = M / DecoderUnits,
  parameter int unsigned ResultWidth  = halut_pkg::ResultWidth,
  parameter int unsigned MAddrWidth   = $clog2(M),
  parameter int unsigned RowCntWidth  = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic [DecUnitsX-1:0][ResultWidth-1:0] result_i,
  input  logic [DecUnitsX-1:0]                  valid_i,
  input  logic [DecUnitsX-1:0][MAddrWidth-1:0]  m_addr_i,
  output logic [ResultWidth-1:0]                out_data_o,
  output logic [MAddrWidth-1:0]                 out_m_addr_o,
  output logic                                  out_last_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [RowCntWidth-1:0]                row_idx_o,
  output logic [2:0]                            err_o
);

  import halut_pkg::*;

  localparam logic [MAddrWidth-1:0] IdxLast = MAddrWidth'(M - 1);

  coll_state_e            state_q, state_d;
  logic [MAddrWidth-1:0]  idx_q, idx_d;
  logic                   rb_q, rb_d;
  logic                   wb_q, wb_d;
  logic [1:0]             bank_full_q, bank_full_d;
  logic [RowCntWidth-1:0] row_q, row_d;
  logic [ErrWidth-1:0]    err_q, err_d;
  logic                   release_bank;

  logic [DecUnitsX-1:0]                  lane_in_range;
  logic [DecUnitsX-1:0]                  lane_wr;
  logic [1:0][DecUnitsX-1:0]             bank_wr_en;
  logic [1:0]                            bank_clear;
  logic [1:0]                            bank_full_pulse;
  logic [1:0]                            bank_dup;
  logic [1:0][ResultWidth-1:0]           bank_rd_data;
  logic                                  complete;

  genvar gi;
  generate
    for (gi = 0; gi < DecUnitsX; gi++) begin : g_lane
      // Lane x owns columns [x*DecoderUnits, (x+1)*DecoderUnits-1].
      assign lane_in_range[gi] = (32'(m_addr_i[gi]) / DecoderUnits) == 32'(gi);
      assign lane_wr[gi]       = valid_i[gi] & lane_in_range[gi] & ~bank_full_q[wb_q];
    end

    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_wr_en[gi] = (wb_q == 1'(gi)) ? lane_wr : '0;
      // The bank that becomes the write bank starts with an empty bitmap.
      assign bank_clear[gi] = clear_i | (complete & (wb_q != 1'(gi)));

      halut_row_bank #(
        .M           (M),
        .Lanes       (DecUnitsX),
        .ResultWidth (ResultWidth),
        .AddrWidth   (MAddrWidth)
      ) u_bank (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (bank_clear[gi]),
        .wr_en_i   (bank_wr_en[gi]),
        .wr_addr_i (m_addr_i),
        .wr_data_i (result_i),
        .rd_idx_i  (idx_q),
        .rd_data_o (bank_rd_data[gi]),
        .full_o    (bank_full_pulse[gi]),
        .dup_o     (bank_dup[gi])
      );
    end
  endgenerate

  assign complete = bank_full_pulse[wb_q];

  // Write side: bank ownership and sticky errors.
  always_comb begin
    bank_full_d = bank_full_q;
    wb_d        = wb_q;
    err_d       = err_q;
    if (complete) begin
      bank_full_d[wb_q] = 1'b1;
      wb_d              = ~wb_q;
    end
    // Completion and release never target the same bank: a full write bank takes no writes.
    if (release_bank) bank_full_d[rb_q] = 1'b0;
    if (|(valid_i & ~lane_in_range))  err_d[ErrRange]     = 1'b1;
    if (|bank_dup)                    err_d[ErrDuplicate] = 1'b1;
    if (bank_full_q[wb_q] && |valid_i) err_d[ErrOverflow] = 1'b1;
    if (clear_i) begin
      bank_full_d = '0;
      wb_d        = 1'b0;
      err_d       = '0;
    end
  end

  // Read FSM: next state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rb_d         = rb_q;
    row_d        = row_q;
    release_bank = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rb_q]) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (out_ready_i) begin
          if (idx_q == IdxLast) begin
            release_bank = 1'b1;
            rb_d         = ~rb_q;
            row_d        = row_q + RowCntWidth'(1);
            idx_d        = '0;
            // Continue straight into the other bank when it is already waiting.
            state_d      = bank_full_q[~rb_q] ? STREAM : IDLE;
          end else begin
            idx_d = idx_q + MAddrWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d      = IDLE;
      idx_d        = '0;
      rb_d         = 1'b0;
      row_d        = '0;
      release_bank = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rb_q        <= 1'b0;
      wb_q        <= 1'b0;
      bank_full_q <= '0;
      row_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rb_q        <= rb_d;
      wb_q        <= wb_d;
      bank_full_q <= bank_full_d;
      row_q       <= row_d;
      err_q       <= err_d;
    end
  end

  // Outputs: zero outside STREAM so buffer garbage never leaks out.
  always_comb begin
    out_valid_o  = 1'b0;
    out_data_o   = '0;
    out_m_addr_o = '0;
    out_last_o   = 1'b0;
    if (state_q == STREAM) begin
      out_valid_o  = 1'b1;
      out_data_o   = bank_rd_data[rb_q];
      out_m_addr_o = idx_q;
      out_last_o   = (idx_q == IdxLast);
    end
  end

  assign row_idx_o = row_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_halut_result_collector.sv
// Bench for halut_result_collector (M=8, DecoderUnits=4, two lanes).
// Stimulus pushes expected words into a queue; a negedge monitor pops and
// compares on every handshake and checks that stalled outputs hold.
module tb_halut_result_collector;

  localparam int M  = 8;
  localparam int DU = 4;
  localparam int LX = 2;
  localparam int RW = 32;
  localparam int AW = 3;
  localparam int CW = 16;

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic                   clear_i;
  logic [LX-1:0][RW-1:0]  result_i;
  logic [LX-1:0]          valid_i;
  logic [LX-1:0][AW-1:0]  m_addr_i;
  logic [RW-1:0]          out_data_o;
  logic [AW-1:0]          out_m_addr_o;
  logic                   out_last_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [CW-1:0]          row_idx_o;
  logic [2:0]             err_o;

  halut_result_collector #(
    .M            (M),
    .DecoderUnits (DU),
    .ResultWidth  (RW),
    .RowCntWidth  (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .result_i     (result_i),
    .valid_i      (valid_i),
    .m_addr_i     (m_addr_i),
    .out_data_o   (out_data_o),
    .out_m_addr_o (out_m_addr_o),
    .out_last_o   (out_last_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .row_idx_o    (row_idx_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    logic [AW-1:0] m;
    logic          last;
    logic [CW-1:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_row  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          stall_pending = 1'b0;
  logic [RW-1:0] held_data;
  logic [AW-1:0] held_m;
  logic          held_last;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst_ni) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        chk("hold_valid", 64'(out_valid_o), 64'd1);
        chk("hold_data",  64'(out_data_o),  64'(held_data));
        chk("hold_maddr", 64'(out_m_addr_o), 64'(held_m));
        chk("hold_last",  64'(out_last_o),  64'(held_last));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got m_addr %0d data 0x%0h, expected no output", out_m_addr_o, out_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          $display("word row=%0d m=%0d data=0x%0h last=%0d", row_idx_o, out_m_addr_o, out_data_o, out_last_o);
          chk("out_data",  64'(out_data_o),   64'(mon_e.data));
          chk("out_maddr", 64'(out_m_addr_o), 64'(mon_e.m));
          chk("out_last",  64'(out_last_o),   64'(mon_e.last));
          chk("row_idx",   64'(row_idx_o),    64'(mon_e.row));
        end
      end
      stall_pending = out_valid_o && !out_ready_i;
      held_data     = out_data_o;
      held_m        = out_m_addr_o;
      held_last     = out_last_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [RW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [RW-1:0] d1);
    valid_i     = {v1, v0};
    m_addr_i[0] = a0;
    result_i[0] = d0;
    m_addr_i[1] = a1;
    result_i[1] = d1;
    @(posedge clk);
    #1;
    valid_i = '0;
  endtask

  task automatic push_word(input int m, input logic [RW-1:0] d);
    exp_t e;
    e.data = d;
    e.m    = AW'(m);
    e.last = (m == M - 1);
    e.row  = CW'(exp_row);
    exp_q.push_back(e);
  endtask

  // Lane0 fills columns 0..3, lane1 columns 4..7, one pair per cycle.
  task automatic fill_row(input logic [RW-1:0] base);
    for (int i = 0; i < 4; i++)
      drive(1'b1, AW'(i), base + RW'(i), 1'b1, AW'(i + 4), base + RW'(i + 4));
    for (int i = 0; i < M; i++) push_word(i, base + RW'(i));
    exp_row++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int vcnt;
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    valid_i     = '0;
    m_addr_i    = '0;
    result_i    = '0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid_o),  64'd0);
    chk("rst_data",  64'(out_data_o),   64'd0);
    chk("rst_maddr", 64'(out_m_addr_o), 64'd0);
    chk("rst_last",  64'(out_last_o),   64'd0);
    chk("rst_row",   64'(row_idx_o),    64'd0);
    chk("rst_err",   64'(err_o),        64'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Fill with latency check
    out_ready_i = 1'b1;
    fill_row(32'h10);
    @(negedge clk);
    chk("latency_t1_valid", 64'(out_valid_o), 64'd0);
    @(negedge clk);
    chk("latency_t2_valid", 64'(out_valid_o), 64'd1);
    wait_drain("fill_drained");

    // Backpressure 1,0,0,1,...
    fill_row(32'h20);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      out_ready_i = ((n % 4) == 0) || ((n % 4) == 3);
      @(posedge clk);
      #1;
      n++;
    end
    out_ready_i = 1'b1;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back rows, no bubble
    out_ready_i = 1'b0;
    fill_row(32'h30);
    fill_row(32'h40);
    repeat (2) @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_valid_o) vcnt++;
    end
    chk("b2b_valid_cycles", 64'(vcnt), 64'd16);
    wait_drain("b2b_drained");
    chk("b2b_err", 64'(err_o), 64'd0);

    // Overflow with both banks held
    out_ready_i = 1'b0;
    fill_row(32'h50);
    fill_row(32'h60);
    drive(1'b1, 3'd2, 32'hEE, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    chk("ovf_err", 64'(err_o), 64'h1);
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    wait_drain("ovf_drained");

    // Duplicate on lane1 m=5, out-of-range lane0 m=6
    drive(1'b1, 3'd0, 32'h70, 1'b1, 3'd5, 32'h55);
    drive(1'b1, 3'd1, 32'h71, 1'b1, 3'd5, 32'h99);
    drive(1'b1, 3'd2, 32'h72, 1'b1, 3'd4, 32'h74);
    drive(1'b1, 3'd3, 32'h73, 1'b1, 3'd6, 32'h76);
    drive(1'b1, 3'd6, 32'hBAD, 1'b1, 3'd7, 32'h77);
    push_word(0, 32'h70); push_word(1, 32'h71); push_word(2, 32'h72); push_word(3, 32'h73);
    push_word(4, 32'h74); push_word(5, 32'h99); push_word(6, 32'h76); push_word(7, 32'h77);
    exp_row++;
    wait_drain("dup_drained");
    chk("dup_range_err", 64'(err_o), 64'h7);

    // Reset mid-stream at word 3
    fill_row(32'h80);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(out_valid_o && out_m_addr_o == 3'd3) && n < 50);
    chk("reach_word3", 64'(out_valid_o && out_m_addr_o == 3'd3), 64'd1);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_err",   64'(err_o),       64'd0);
    @(posedge clk);
    #1;
    rst_ni  = 1'b1;
    exp_row = 0;
    fill_row(32'h90);
    wait_drain("post_rst_drained");
    chk("post_rst_err", 64'(err_o), 64'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
